// File: rtl/multi_cycle_controller.sv
// -----------------------------------------------------------------------------
// multi_cycle_controller
//
// Moore-style control FSM for the multi-cycle MIPS datapath. One instruction
// is sequenced over 3-5 cycles (fetch, decode, execute, memory, writeback).
// Supported opcodes: RTYPE, LW, SW, BEQ, ADDI, J. Anything else sends the FSM
// to HALT and raises the sticky illegal flag. Memory accesses in FETCH, MEMRD
// and MEMWR hold until mem_ready.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   op[5:0]    in   opcode from the instruction register (valid from DECODE)
//   zero       in   ALU zero flag
//   mem_ready  in   memory completed the current access this cycle
//   iord       out  memory address select: 0 = PC, 1 = ALUOut
//   memwrite   out  memory write strobe
//   irwrite    out  instruction register load
//   regdst     out  register destination: 1 = rd, 0 = rt
//   memtoreg   out  writeback source: 1 = data register, 0 = ALUOut
//   regwrite   out  register file write
//   alusrca    out  ALU A: 0 = PC, 1 = rs
//   alusrcb    out  ALU B: 00 rt, 01 const 4, 10 sext imm, 11 imm<<2
//   pcsrc      out  PC source: 00 ALU result, 01 ALUOut, 10 jump target
//   pcen       out  PC load = pcwrite | (branch & zero)
//   aluop[2:0] out  ALU operation class
//   state[3:0] out  current state encoding (debug / verification)
//   illegal    out  sticky: an unsupported opcode was decoded
// -----------------------------------------------------------------------------
module multi_cycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] aluop,
  output logic [3:0] state,
  output logic       illegal
);

  // Opcode values shared with the single-cycle decoder (common.svh).
  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] J     = 6'b000010;

  // ALU operation classes (common.svh). ALU_NO_USE defers to the funct field.
  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_NO_USE = 3'b111;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_RTEX   = 4'd6;
  localparam logic [3:0] S_RTWB   = 4'd7;
  localparam logic [3:0] S_BEQEX  = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JEX    = 4'd11;
  localparam logic [3:0] S_HALT   = 4'd12;

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       pcwrite;
  logic       branch;

  // Next-state and sticky illegal flag.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          LW, SW: state_d = S_MEMADR;
          RTYPE:  state_d = S_RTEX;
          BEQ:    state_d = S_BEQEX;
          ADDI:   state_d = S_ADDIEX;
          J:      state_d = S_JEX;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (op == LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTEX:   state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_BEQEX:  state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JEX:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;  // encodings 13-15 recover to FETCH
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore outputs; FETCH additionally gates its loads with mem_ready so the
  // IR and PC only capture on the cycle the fetch completes.
  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALU_ADD;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: alusrcb = 2'b11;  // branch target precomputed into ALUOut
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTEX: begin
        alusrca = 1'b1;
        aluop   = ALU_NO_USE;
      end
      S_RTWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALU_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;  // HALT and unreachable encodings: all enables stay low
    endcase
  end

  assign pcen    = pcwrite | (branch & zero);
  assign state   = state_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_controller
//
// Directed bench for multi_cycle_controller. Inputs change on the falling
// edge; outputs are checked 1 time unit later, well away from the rising edge.
// Every task starts and ends at a falling edge with the FSM in FETCH (except
// test_reset, which establishes that condition).
// -----------------------------------------------------------------------------
module tb_multi_cycle_controller;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] J     = 6'b000010;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_NO_USE = 3'b111;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen;
  logic [2:0] aluop;
  logic [3:0] state;
  logic       illegal;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multi_cycle_controller dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .iord      (iord),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .pcsrc     (pcsrc),
    .pcen      (pcen),
    .aluop     (aluop),
    .state     (state),
    .illegal   (illegal)
  );

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; op = LW; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (state !== 4'd0) begin
      n_err++; $display("FAIL reset_state: got %0d want 0", state);
    end
    n_cmp++;
    if (illegal !== 1'b0) begin
      n_err++; $display("FAIL reset_illegal: got %b want 0", illegal);
    end
    n_cmp++;
    if ({iord, alusrca, alusrcb, irwrite, pcen} !== 6'b0_0_01_1_1) begin
      n_err++;
      $display("FAIL reset_fetch_outputs: got iord=%b alusrca=%b alusrcb=%b irwrite=%b pcen=%b want 0 0 01 1 1",
               iord, alusrca, alusrcb, irwrite, pcen);
    end
    $display("reset: state=%0d illegal=%b", state, illegal);
  endtask

  task automatic test_lw();
    int seq [6] = '{0, 1, 2, 3, 4, 0};
    op = LW; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_cmp++;
      if (state !== 4'(seq[i])) begin
        n_err++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, seq[i]);
      end
      n_cmp++;
      if ({irwrite, pcen} !== {2{seq[i] == 0}}) begin
        n_err++; $display("FAIL lw_irwrite_pcen[%0d]: got %b%b want %b", i, irwrite, pcen, seq[i] == 0);
      end
      n_cmp++;
      if ({regwrite, memtoreg} !== {2{seq[i] == 4}}) begin
        n_err++; $display("FAIL lw_regwrite_memtoreg[%0d]: got %b%b want %b", i, regwrite, memtoreg, seq[i] == 4);
      end
      if (seq[i] == 2) begin
        n_cmp++;
        if ({alusrca, alusrcb} !== 3'b1_10) begin
          n_err++; $display("FAIL lw_memadr_alusrc: got %b %b want 1 10", alusrca, alusrcb);
        end
      end
      if (seq[i] == 1) begin
        n_cmp++;
        if ({alusrca, alusrcb} !== 3'b0_11) begin
          n_err++; $display("FAIL lw_decode_alusrc: got %b %b want 0 11", alusrca, alusrcb);
        end
      end
    end
    $display("lw: 5-cycle sequence done, state=%0d", state);
  endtask

  task automatic test_sw();
    int   seq [7] = '{0, 1, 2, 5, 5, 5, 0};
    logic mr  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    op = SW;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = mr[i];
      #1;
      n_cmp++;
      if (state !== 4'(seq[i])) begin
        n_err++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, seq[i]);
      end
      n_cmp++;
      if (regwrite !== 1'b0) begin
        n_err++; $display("FAIL sw_regwrite[%0d]: got %b want 0", i, regwrite);
      end
      if (seq[i] == 5) begin
        n_cmp++;
        if ({memwrite, iord} !== 2'b11) begin
          n_err++; $display("FAIL sw_memwr[%0d]: got memwrite=%b iord=%b want 1 1", i, memwrite, iord);
        end
      end else begin
        n_cmp++;
        if (memwrite !== 1'b0) begin
          n_err++; $display("FAIL sw_memwrite_idle[%0d]: got %b want 0", i, memwrite);
        end
      end
    end
    $display("sw: 6-cycle sequence with 2 wait cycles done, state=%0d", state);
  endtask

  task automatic test_beq(input logic zero_val);
    int seq [4] = '{0, 1, 8, 0};
    op = BEQ; mem_ready = 1'b1; zero = zero_val;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_cmp++;
      if (state !== 4'(seq[i])) begin
        n_err++; $display("FAIL beq_state[%0d] zero=%b: got %0d want %0d", i, zero_val, state, seq[i]);
      end
      if (seq[i] == 8) begin
        n_cmp++;
        if ({aluop, pcsrc, alusrca, alusrcb} !== {ALU_SUB, 2'b01, 1'b1, 2'b00}) begin
          n_err++; $display("FAIL beq_ex_ctrl: got aluop=%b pcsrc=%b alusrca=%b alusrcb=%b want 001 01 1 00",
                            aluop, pcsrc, alusrca, alusrcb);
        end
        n_cmp++;
        if (pcen !== zero_val) begin
          n_err++; $display("FAIL beq_pcen zero=%b: got %b want %b", zero_val, pcen, zero_val);
        end
      end
      if (seq[i] == 1) begin
        n_cmp++;
        if (pcen !== 1'b0) begin
          n_err++; $display("FAIL beq_decode_pcen zero=%b: got %b want 0", zero_val, pcen);
        end
      end
    end
    zero = 1'b0;
    $display("beq zero=%b: 3-cycle sequence done", zero_val);
  endtask

  task automatic test_back_to_back();
    int         seq [12] = '{0, 1, 6, 7, 0, 1, 9, 10, 0, 1, 11, 0};
    logic [5:0] ops [12] = '{RTYPE, RTYPE, RTYPE, RTYPE, ADDI, ADDI, ADDI, ADDI, J, J, J, J};
    mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      op = ops[i];
      #1;
      n_cmp++;
      if (state !== 4'(seq[i])) begin
        n_err++; $display("FAIL b2b_state[%0d]: got %0d want %0d", i, state, seq[i]);
      end
      case (seq[i])
        6: begin
          n_cmp++;
          if ({aluop, alusrca, alusrcb} !== {ALU_NO_USE, 1'b1, 2'b00}) begin
            n_err++; $display("FAIL b2b_rtex: got aluop=%b alusrca=%b alusrcb=%b want 111 1 00", aluop, alusrca, alusrcb);
          end
        end
        7: begin
          n_cmp++;
          if ({regdst, memtoreg, regwrite} !== 3'b101) begin
            n_err++; $display("FAIL b2b_rtwb: got regdst=%b memtoreg=%b regwrite=%b want 1 0 1", regdst, memtoreg, regwrite);
          end
        end
        9: begin
          n_cmp++;
          if ({aluop, alusrca, alusrcb, regwrite} !== {ALU_ADD, 1'b1, 2'b10, 1'b0}) begin
            n_err++; $display("FAIL b2b_addiex: got aluop=%b alusrca=%b alusrcb=%b regwrite=%b want 000 1 10 0",
                              aluop, alusrca, alusrcb, regwrite);
          end
        end
        10: begin
          n_cmp++;
          if ({regdst, memtoreg, regwrite} !== 3'b001) begin
            n_err++; $display("FAIL b2b_addiwb: got regdst=%b memtoreg=%b regwrite=%b want 0 0 1", regdst, memtoreg, regwrite);
          end
        end
        11: begin
          n_cmp++;
          if ({pcsrc, pcen} !== 3'b10_1) begin
            n_err++; $display("FAIL b2b_jex: got pcsrc=%b pcen=%b want 10 1", pcsrc, pcen);
          end
        end
        default: ;
      endcase
    end
    $display("back_to_back: RTYPE+ADDI+J in 11 cycles done, state=%0d", state);
  endtask

  task automatic test_illegal();
    op = 6'b111111; mem_ready = 1'b1; zero = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({state, illegal} !== {4'd1, 1'b0}) begin
      n_err++; $display("FAIL ill_decode: got state=%0d illegal=%b want 1 0", state, illegal);
    end
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({state, illegal} !== {4'd12, 1'b1}) begin
        n_err++; $display("FAIL ill_halt[%0d]: got state=%0d illegal=%b want 12 1", i, state, illegal);
      end
      n_cmp++;
      if ({irwrite, memwrite, regwrite, pcen} !== 4'b0000) begin
        n_err++; $display("FAIL ill_enables[%0d]: got irwrite=%b memwrite=%b regwrite=%b pcen=%b want 0000",
                          i, irwrite, memwrite, regwrite, pcen);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; zero = 1'b0; op = LW;
    #1;
    n_cmp++;
    if ({state, illegal} !== {4'd0, 1'b0}) begin
      n_err++; $display("FAIL ill_reset: got state=%0d illegal=%b want 0 0", state, illegal);
    end
    $display("illegal: HALT held, reset recovered state=%0d illegal=%b", state, illegal);
  endtask

  task automatic test_reset_mid();
    int   seq [5] = '{0, 1, 2, 3, 3};
    logic mr  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic saw_regwrite = 1'b0;
    op = LW;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = mr[i];
      #1;
      if (regwrite === 1'b1) saw_regwrite = 1'b1;
      n_cmp++;
      if (state !== 4'(seq[i])) begin
        n_err++; $display("FAIL mid_state[%0d]: got %0d want %0d", i, state, seq[i]);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    if (regwrite === 1'b1) saw_regwrite = 1'b1;
    n_cmp++;
    if (state !== 4'd0) begin
      n_err++; $display("FAIL mid_reset_state: got %0d want 0", state);
    end
    // One more cycle so any stray MEMWB would show up.
    mem_ready = 1'b0;
    @(negedge clk); #1;
    if (regwrite === 1'b1) saw_regwrite = 1'b1;
    n_cmp++;
    if (state !== 4'd0) begin
      n_err++; $display("FAIL mid_fetch_hold: got %0d want 0", state);
    end
    n_cmp++;
    if (saw_regwrite !== 1'b0) begin
      n_err++; $display("FAIL mid_no_regwrite: got %b want 0", saw_regwrite);
    end
    mem_ready = 1'b1;
    $display("reset_mid: aborted LW in MEMRD, state=%0d", state);
  endtask

  initial begin
    reset = 1'b1; op = LW; zero = 1'b0; mem_ready = 1'b1;
    test_reset();
    test_lw();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
